uart_rx: RTL and testbench

Serial receive half of the board-to-board switch/LED link. Deserializes 8N1 UART frames from the `rx` pin into bytes. Each byte with a valid stop bit is presented on `data` with a one-cycle `data_valid` strobe and latched onto `leds`. The block sits beside the switch-driven transmitter inside `uart`, taking `rx` straight from the partner FPGA's `tx`.

---
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver for the board-to-board switch/LED link.
//
// Two-flop synchronizer on rx, then a bit-timing FSM that checks the start
// bit at its midpoint and samples data and stop bits one bit-time apart.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   rx           asynchronous serial input, idle high
//   data         last correctly framed byte
//   data_valid   one-cycle strobe, data was just updated
//   framing_err  one-cycle strobe, stop bit sampled 0
//   busy         high while a frame is in progress (any state but idle)
//   leds         display register, mirrors data
module uart_rx #(
   parameter int unsigned CLK_FREQ     = 50000000,
   parameter int unsigned BAUD_RATE    = 9600,
   parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
   parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       framing_err,
   output logic       busy,
   output logic [7:0] leds
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntBitEnd  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntHalfEnd = CntW'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } state_e;

   logic            rx_meta_q, rx_s_q;
   logic [1:0]      fill_q;
   logic            armed_q, armed_d;
   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            dv_q, dv_d;
   logic            fe_q, fe_d;

   // Synchronizer. fill_q tracks when rx_s_q holds a real line sample rather
   // than its reset value.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         fill_q    <= 2'b00;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         fill_q    <= {fill_q[0], 1'b1};
      end
   end

   // A start is accepted only after the real line has been seen high since
   // reset, so a line caught low mid-frame by reset is not decoded.
   assign armed_d = armed_q | (fill_q[1] & rx_s_q);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      dv_d      = 1'b0;
      fe_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (armed_q && !rx_s_q) state_d = StStart;
         end
         StStart: begin
            if (cnt_q == CntHalfEnd) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  state_d   = StData;
                  bit_idx_d = '0;
               end else begin
                  state_d = StIdle;  // glitch
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StData: begin
            if (cnt_q == CntBitEnd) begin
               cnt_d     = '0;
               shift_d   = {rx_s_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = StStop;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StStop: begin
            if (cnt_q == CntBitEnd) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  data_d  = shift_q;
                  dv_d    = 1'b1;
                  state_d = StIdle;
               end else begin
                  fe_d    = 1'b1;
                  state_d = StBreak;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StBreak: begin
            cnt_d = '0;
            if (rx_s_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         armed_q   <= 1'b0;
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         dv_q      <= 1'b0;
         fe_q      <= 1'b0;
      end else begin
         armed_q   <= armed_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         dv_q      <= dv_d;
         fe_q      <= fe_d;
      end
   end

   assign data        = data_q;
   assign leds        = data_q;
   assign data_valid  = dv_q;
   assign framing_err = fe_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

   localparam int unsigned ClkFreq  = 16;
   localparam int unsigned BaudRate = 1;
   localparam int Cpb       = ClkFreq / BaudRate;
   localparam int Hb        = Cpb / 2;
   localparam int StrobeLat = 2 + Hb + 9 * Cpb;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] data;
   logic       data_valid;
   logic       framing_err;
   logic       busy;
   logic [7:0] leds;

   uart_rx #(
      .CLK_FREQ (ClkFreq),
      .BAUD_RATE(BaudRate)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .data       (data),
      .data_valid (data_valid),
      .framing_err(framing_err),
      .busy       (busy),
      .leds       (leds)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;
   int last_e = 0;

   typedef struct {
      bit         fe;
      logic [7:0] d;
      logic [7:0] l;
      logic       busy;
      int         cyc;
   } ev_t;
   ev_t evq[$];
   ev_t expq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Strobe monitor: logs every strobe cycle with the outputs seen then.
   always @(negedge clk) begin
      if (data_valid || framing_err) begin
         check("strobe_exclusive", {31'b0, data_valid & framing_err}, 32'h0);
         evq.push_back('{fe: framing_err, d: data, l: leds, busy: busy, cyc: cyc});
      end
   end

   // Called on a negedge; returns on a negedge with rx released high.
   task automatic send_frame(input logic [7:0] b, input bit stop_good, input int stop_len);
      rx = 1'b0;
      last_e = cyc + 1;
      repeat (Cpb) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (Cpb) @(negedge clk);
      end
      rx = stop_good;
      repeat (stop_len) @(negedge clk);
      rx = 1'b1;
   endtask

   typedef struct {
      logic [7:0] b;
      bit         stop_good;
      bit         exp_fe;
      logic [7:0] exp_data;
   } vec_t;
   vec_t vecs[6];

   initial begin
      int es[3];
      logic [7:0] exp_data;
      logic [7:0] rb;
      bit good;
      int gap;

      vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5};
      vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'hA5};
      vecs[2] = '{8'h00, 1'b1, 1'b0, 8'h00};
      vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'h00};
      vecs[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF};
      vecs[5] = '{8'h5A, 1'b1, 1'b0, 8'h5A};

      // Reset values
      reset = 1'b1;
      rx = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_data", {24'b0, data}, 32'h0);
      check("rst_leds", {24'b0, leds}, 32'h0);
      check("rst_dv", {31'b0, data_valid}, 32'h0);
      check("rst_fe", {31'b0, framing_err}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      reset = 1'b0;
      repeat (8) @(negedge clk);

      // Table-driven frames
      for (int v = 0; v < 6; v++) begin
         evq.delete();
         send_frame(vecs[v].b, vecs[v].stop_good, Cpb);
         repeat (6) @(negedge clk);
         check($sformatf("vec%0d_count", v), evq.size(), 32'd1);
         if (evq.size() > 0) begin
            check($sformatf("vec%0d_fe", v), {31'b0, evq[0].fe}, {31'b0, vecs[v].exp_fe});
            check($sformatf("vec%0d_data", v), {24'b0, evq[0].d}, {24'b0, vecs[v].exp_data});
            check($sformatf("vec%0d_leds", v), {24'b0, evq[0].l}, {24'b0, vecs[v].exp_data});
            check($sformatf("vec%0d_busy", v), {31'b0, evq[0].busy}, {31'b0, vecs[v].exp_fe});
            check($sformatf("vec%0d_lat", v), evq[0].cyc, last_e + StrobeLat);
         end
         check($sformatf("vec%0d_out", v), {24'b0, data}, {24'b0, vecs[v].exp_data});
      end

      // Glitch rejection
      evq.delete();
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      check("glitch_busy_hi", {31'b0, busy}, 32'h1);
      repeat (10) @(negedge clk);
      check("glitch_busy_lo", {31'b0, busy}, 32'h0);
      check("glitch_nostrobe", evq.size(), 32'd0);
      check("glitch_data", {24'b0, data}, 32'h5A);

      // Back-to-back frames
      evq.delete();
      send_frame(8'h01, 1'b1, Cpb);
      es[0] = last_e;
      send_frame(8'hFF, 1'b1, Cpb);
      es[1] = last_e;
      send_frame(8'h00, 1'b1, Cpb);
      es[2] = last_e;
      repeat (6) @(negedge clk);
      check("b2b_count", evq.size(), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (evq.size() > i) begin
            check($sformatf("b2b%0d_data", i), {24'b0, evq[i].d},
                  (i == 0) ? 32'h01 : (i == 1) ? 32'hFF : 32'h00);
            check($sformatf("b2b%0d_lat", i), evq[i].cyc, es[i] + StrobeLat);
         end
      end

      // Framing error with a held-low stop bit
      evq.delete();
      send_frame(8'h3C, 1'b0, 40);
      check("fe_busy_held", {31'b0, busy}, 32'h1);
      check("fe_count", evq.size(), 32'd1);
      if (evq.size() > 0) check("fe_flag", {31'b0, evq[0].fe}, 32'h1);
      check("fe_data", {24'b0, data}, 32'h00);
      check("fe_leds", {24'b0, leds}, 32'h00);
      repeat (5) @(negedge clk);
      check("fe_busy_rel", {31'b0, busy}, 32'h0);
      check("fe_no_more", evq.size(), 32'd1);
      evq.delete();
      send_frame(8'h55, 1'b1, Cpb);
      repeat (6) @(negedge clk);
      check("fe_next_count", evq.size(), 32'd1);
      check("fe_next_data", {24'b0, data}, 32'h55);

      // Reset during bit 4 of 0x81
      evq.delete();
      rb = 8'h81;
      rx = 1'b0;
      repeat (Cpb) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = rb[i];
         repeat (Cpb) @(negedge clk);
      end
      rx = rb[4];
      repeat (Hb) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_data", {24'b0, data}, 32'h0);
      check("mid_rst_leds", {24'b0, leds}, 32'h0);
      check("mid_rst_strobes", {30'b0, data_valid, framing_err}, 32'h0);
      check("mid_rst_busy", {31'b0, busy}, 32'h0);
      repeat (Cpb - Hb - 1) @(negedge clk);
      for (int i = 5; i < 8; i++) begin
         rx = rb[i];
         repeat (Cpb) @(negedge clk);
      end
      rx = 1'b1;
      repeat (Cpb + 20) @(negedge clk);
      check("mid_rst_nostrobe", evq.size(), 32'd0);
      send_frame(8'h42, 1'b1, Cpb);
      repeat (6) @(negedge clk);
      check("mid_rst_next_count", evq.size(), 32'd1);
      check("mid_rst_next_data", {24'b0, data}, 32'h42);

      // Randomized frames against a frame-level model
      evq.delete();
      expq.delete();
      exp_data = 8'h42;
      for (int k = 0; k < 24; k++) begin
         rb = 8'($urandom);
         good = ($urandom_range(0, 3) != 0);
         send_frame(rb, good, Cpb);
         if (good) exp_data = rb;
         expq.push_back('{fe: !good, d: exp_data, l: exp_data, busy: !good, cyc: 0});
         gap = good ? $urandom_range(0, 4) : $urandom_range(3, 6);
         repeat (gap) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      check("rand_count", evq.size(), expq.size());
      for (int i = 0; i < expq.size(); i++) begin
         if (evq.size() > i) begin
            check($sformatf("rand%0d_fe", i), {31'b0, evq[i].fe}, {31'b0, expq[i].fe});
            check($sformatf("rand%0d_data", i), {24'b0, evq[i].d}, {24'b0, expq[i].d});
            check($sformatf("rand%0d_leds", i), {24'b0, evq[i].l}, {24'b0, expq[i].l});
         end
      end
      check("rand_final_data", {24'b0, data}, {24'b0, exp_data});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
